// File: rtl/mac_lane_acc.sv
// Multi-lane signed MAC: per-beat lane products, lane sum, kernel accumulate with bias, ReLU/shift/saturate.
// Result valid 3 cycles after the i_last beat is presented; o_valid && !o_ready freezes the whole pipeline and drops i_ready.
module mac_lane_acc #(
    parameter int I_BW    = 8,
    parameter int W_BW    = 8,
    parameter int N_LANE  = 5,
    parameter int ACC_BW  = 24,
    parameter int O_BW    = 8,
    parameter int O_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     global_rst_n,
    input  logic                     clr,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic                     i_last,
    input  logic [N_LANE*I_BW-1:0]   i_data,
    input  logic [N_LANE*W_BW-1:0]   i_weight,
    input  logic [ACC_BW-1:0]        i_bias,
    input  logic                     i_relu_en,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [O_BW-1:0]          o_data,
    output logic [ACC_BW-1:0]        o_acc
);

    localparam int P_BW = I_BW + W_BW;
    localparam logic signed [ACC_BW-1:0] L_SAT_MAX = ACC_BW'((2 ** (O_BW - 1)) - 1);
    localparam logic signed [ACC_BW-1:0] L_SAT_MIN = ~L_SAT_MAX;

    logic                     w_stall;
    logic                     w_accept;
    logic signed [P_BW-1:0]   w_prod [N_LANE];
    logic signed [ACC_BW-1:0] w_lane_sum;
    logic signed [ACC_BW-1:0] w_acc_next;
    logic signed [ACC_BW-1:0] w_relu_v;
    logic signed [ACC_BW-1:0] w_shift;
    logic        [O_BW-1:0]   w_sat;
    logic                     w_result;

    logic                     r_s1_valid;
    logic signed [P_BW-1:0]   r_s1_prod [N_LANE];
    logic                     r_s1_last;
    logic signed [ACC_BW-1:0] r_s1_bias;
    logic                     r_s1_relu;

    logic                     r_s2_valid;
    logic signed [ACC_BW-1:0] r_s2_sum;
    logic                     r_s2_last;
    logic signed [ACC_BW-1:0] r_s2_bias;
    logic                     r_s2_relu;

    logic signed [ACC_BW-1:0] r_acc;
    logic                     r_first;

    assign w_stall  = o_valid && !o_ready;
    assign i_ready  = !w_stall;
    assign w_accept = i_valid && i_ready;
    assign w_result = r_s2_valid && r_s2_last;

    always_comb begin
        for (int k = 0; k < N_LANE; k++) begin
            w_prod[k] = P_BW'($signed(i_data[k*I_BW +: I_BW]) * $signed(i_weight[k*W_BW +: W_BW]));
        end
    end

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < N_LANE; k++) begin
            w_lane_sum = w_lane_sum + ACC_BW'(r_s1_prod[k]);
        end
    end

    // Bias only enters on the first beat of a kernel; later beats add onto the running sum.
    always_comb begin
        w_acc_next = r_first ? (r_s2_bias + r_s2_sum) : (r_acc + r_s2_sum);
        w_relu_v   = (r_s2_relu && w_acc_next[ACC_BW-1]) ? '0 : w_acc_next;
        w_shift    = w_relu_v >>> O_SHIFT;
        w_sat      = w_shift[O_BW-1:0];
        if (w_shift > L_SAT_MAX) begin
            w_sat = L_SAT_MAX[O_BW-1:0];
        end else if (w_shift < L_SAT_MIN) begin
            w_sat = L_SAT_MIN[O_BW-1:0];
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bias  <= '0;
            r_s1_relu  <= 1'b0;
            for (int k = 0; k < N_LANE; k++) r_s1_prod[k] <= '0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bias  <= '0;
            r_s1_relu  <= 1'b0;
            for (int k = 0; k < N_LANE; k++) r_s1_prod[k] <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            r_s1_last  <= i_last;
            r_s1_bias  <= $signed(i_bias);
            r_s1_relu  <= i_relu_en;
            for (int k = 0; k < N_LANE; k++) r_s1_prod[k] <= w_prod[k];
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_last  <= 1'b0;
            r_s2_bias  <= '0;
            r_s2_relu  <= 1'b0;
        end else if (clr) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_last  <= 1'b0;
            r_s2_bias  <= '0;
            r_s2_relu  <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sum   <= w_lane_sum;
            r_s2_last  <= r_s1_last;
            r_s2_bias  <= r_s1_bias;
            r_s2_relu  <= r_s1_relu;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_acc   <= '0;
            r_first <= 1'b1;
        end else if (clr) begin
            r_acc   <= '0;
            r_first <= 1'b1;
        end else if (!w_stall && r_s2_valid) begin
            r_acc   <= w_acc_next;
            r_first <= r_s2_last;
        end
    end

    // A new result landing on the handshake edge keeps o_valid high with fresh data.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_acc   <= '0;
        end else if (clr) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_acc   <= '0;
        end else if (!w_stall) begin
            if (w_result) begin
                o_valid <= 1'b1;
                o_data  <= w_sat;
                o_acc   <= w_acc_next;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_lane_acc.sv
// Directed bench: kernel-level model (dot products + bias, wrap, ReLU, shift, clamp) scored against two shift settings.
module tb_mac_lane_acc;

    logic        clk = 1'b0;
    logic        global_rst_n;
    logic        clr;
    logic        i_valid;
    logic        i_ready;
    logic        i_ready2;
    logic        i_last;
    logic [39:0] i_data;
    logic [39:0] i_weight;
    logic [23:0] i_bias;
    logic        i_relu_en;
    logic        o_valid;
    logic        o_valid2;
    logic        o_ready;
    logic [7:0]  o_data;
    logic [7:0]  o_data2;
    logic [23:0] o_acc;
    logic [23:0] o_acc2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint acc;
        longint d0;
        longint d2;
    } res_t;

    res_t   exp_q[$];
    res_t   rec_q[$];
    bit     m_first = 1'b1;
    longint m_sum   = 0;
    longint m_bias  = 0;

    always #5 clk = ~clk;

    mac_lane_acc #(.O_SHIFT(0)) dut0 (
        .clk(clk), .global_rst_n(global_rst_n), .clr(clr),
        .i_valid(i_valid), .i_ready(i_ready), .i_last(i_last),
        .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias), .i_relu_en(i_relu_en),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_acc(o_acc)
    );

    mac_lane_acc #(.O_SHIFT(2)) dut2 (
        .clk(clk), .global_rst_n(global_rst_n), .clr(clr),
        .i_valid(i_valid), .i_ready(i_ready2), .i_last(i_last),
        .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias), .i_relu_en(i_relu_en),
        .o_valid(o_valid2), .o_ready(o_ready), .o_data(o_data2), .o_acc(o_acc2)
    );

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d, input int e);
        logic [7:0] la = a[7:0];
        logic [7:0] lb = b[7:0];
        logic [7:0] lc = c[7:0];
        logic [7:0] ld = d[7:0];
        logic [7:0] le = e[7:0];
        return {le, ld, lc, lb, la};
    endfunction

    function automatic longint post(input longint acc, input bit relu, input int sh);
        longint v;
        v = (relu && acc < 0) ? 0 : acc;
        v = v >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    task automatic model_accept(input logic [39:0] d, input logic [39:0] w, input int bias,
                                input bit last, input bit relu);
        longint dot = 0;
        longint a;
        logic signed [23:0] a24;
        res_t r;
        for (int k = 0; k < 5; k++) begin
            logic signed [7:0] dk = d[k*8 +: 8];
            logic signed [7:0] wk = w[k*8 +: 8];
            dot += longint'(dk) * longint'(wk);
        end
        if (m_first) begin
            m_bias = bias;
            m_sum  = 0;
        end
        m_sum += dot;
        m_first = last;
        if (last) begin
            a = m_sum + m_bias;
            a24 = a[23:0];
            r.acc = longint'(a24);
            r.d0  = post(r.acc, relu, 0);
            r.d2  = post(r.acc, relu, 2);
            exp_q.push_back(r);
        end
    endtask

    task automatic model_flush();
        m_first = 1'b1;
        m_sum   = 0;
        exp_q.delete();
    endtask

    task automatic beat(input logic [39:0] d, input logic [39:0] w, input int bias,
                        input bit last, input bit relu);
        int n = 0;
        @(negedge clk);
        i_valid = 1'b1; i_data = d; i_weight = w; i_bias = bias[23:0];
        i_last = last; i_relu_en = relu;
        #2;
        while (!i_ready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!i_ready) begin
            chk("beat_accept_timeout", 0, 1);
            i_valid = 1'b0;
            return;
        end
        model_accept(d, w, bias, last, relu);
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_rec(input string name, input longint acc, input longint d0, input longint d2);
        res_t r;
        if (rec_q.size() == 0) begin
            chk({name, "_missing"}, 0, 1);
            return;
        end
        r = rec_q.pop_front();
        chk({name, "_acc"}, r.acc, acc);
        chk({name, "_d0"}, r.d0, d0);
        chk({name, "_d2"}, r.d2, d2);
    endtask

    // Per-cycle scoreboard, sampled mid-low-phase after the bench has driven inputs.
    always begin
        @(negedge clk);
        #2;
        if (global_rst_n && !clr) begin
            chk("i_ready_rule", longint'(i_ready), longint'(!(o_valid && !o_ready)));
            chk("valid_pair", longint'(o_valid2), longint'(o_valid));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_o_valid", 1, 0);
                end else begin
                    res_t r;
                    r.acc = longint'($signed(o_acc));
                    r.d0  = longint'($signed(o_data));
                    r.d2  = longint'($signed(o_data2));
                    chk("sb_acc", r.acc, exp_q[0].acc);
                    chk("sb_acc2", longint'($signed(o_acc2)), exp_q[0].acc);
                    chk("sb_d0", r.d0, exp_q[0].d0);
                    chk("sb_d2", r.d2, exp_q[0].d2);
                    if (o_ready) begin
                        void'(exp_q.pop_front());
                        rec_q.push_back(r);
                    end
                end
            end
        end
    end

    initial begin
        global_rst_n = 1'b0; clr = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        i_data = '0; i_weight = '0; i_bias = '0; i_relu_en = 1'b0; o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", longint'(o_valid), 0);
        chk("rst_o_acc", longint'(o_acc), 0);
        chk("rst_o_data", longint'(o_data), 0);
        chk("rst_i_ready", longint'(i_ready), 1);
        @(negedge clk);
        global_rst_n = 1'b1;
        idle(2);

        // Single-beat kernel and its latency: 3*2*5 + 10 = 40.
        beat(pk(3, 3, 3, 3, 3), pk(2, 2, 2, 2, 2), 10, 1'b1, 1'b0);
        @(negedge clk); #2; chk("lat_c1", longint'(o_valid), 0);
        @(negedge clk); #2; chk("lat_c2", longint'(o_valid), 0);
        @(negedge clk); #2; chk("lat_c3", longint'(o_valid), 1);
        idle(3);
        expect_rec("t1", 40, 40, 10);

        // Three beats with bubbles: 6 - 4 + 20 + 1 = 23.
        beat(pk(6, 0, 0, 0, 0), pk(1, 1, 1, 1, 1), 1, 1'b0, 1'b0);
        idle(2);
        beat(pk(-4, 0, 0, 0, 0), pk(1, 1, 1, 1, 1), 77, 1'b0, 1'b0);
        idle(2);
        beat(pk(4, 4, 4, 4, 4), pk(1, 1, 1, 1, 1), 55, 1'b1, 1'b0);
        idle(5);
        expect_rec("t2", 23, 23, 5);

        // Saturation, ReLU and shift rounding toward minus infinity.
        beat(pk(100, 100, 100, 100, 100), pk(2, 2, 2, 2, 2), 0, 1'b1, 1'b0);
        beat(pk(100, 100, 100, 100, 100), pk(-2, -2, -2, -2, -2), 0, 1'b1, 1'b0);
        beat(pk(100, 100, 100, 100, 100), pk(-2, -2, -2, -2, -2), 0, 1'b1, 1'b1);
        beat(pk(-9, 0, 0, 0, 0), pk(1, 0, 0, 0, 0), 0, 1'b1, 1'b0);
        idle(5);
        expect_rec("sat_pos", 1000, 127, 127);
        expect_rec("sat_neg", -1000, -128, -128);
        expect_rec("relu", -1000, 0, 0);
        expect_rec("shift_m9", -9, -9, -3);

        // Backpressure with the next kernel streaming behind the held result.
        o_ready = 1'b0;
        beat(pk(1, 1, 1, 1, 1), pk(1, 1, 1, 1, 1), 0, 1'b1, 1'b0);
        fork
            begin
                beat(pk(2, 2, 2, 2, 2), pk(1, 1, 1, 1, 1), 3, 1'b0, 1'b0);
                beat(pk(1, 1, 1, 1, 1), pk(2, 2, 2, 2, 2), 0, 1'b0, 1'b0);
                beat(pk(1, 0, 0, 0, 0), pk(-1, 0, 0, 0, 0), 0, 1'b1, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk); #2;
                while (!o_valid && n < 20) begin
                    @(negedge clk); #2;
                    n++;
                end
                chk("bp_seen_valid", longint'(o_valid), 1);
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) begin
                        @(negedge clk); #2;
                    end
                    chk("bp_i_ready_low", longint'(i_ready), 0);
                    chk("bp_hold_d0", longint'($signed(o_data)), 5);
                    chk("bp_hold_d2", longint'($signed(o_data2)), 1);
                end
                @(negedge clk);
                o_ready = 1'b1;
            end
        join
        idle(6);
        expect_rec("bp_k1", 5, 5, 1);
        expect_rec("bp_k2", 22, 22, 5);

        // Back-to-back kernels: second one must use its own bias.
        beat(pk(1, 1, 1, 1, 1), pk(1, 1, 1, 1, 1), 7, 1'b1, 1'b0);
        beat(pk(2, 2, 2, 2, 2), pk(1, 1, 1, 1, 1), 100, 1'b1, 1'b0);
        idle(5);
        expect_rec("b2b_k1", 12, 12, 3);
        expect_rec("b2b_k2", 110, 110, 27);

        // Synchronous clear mid-kernel.
        beat(pk(1, 1, 1, 1, 1), pk(1, 1, 1, 1, 1), 50, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_flush();
        chk("clr_o_valid", longint'(o_valid), 0);
        chk("clr_o_acc", longint'(o_acc), 0);
        chk("clr_o_data", longint'(o_data), 0);
        idle(4);
        beat(pk(2, 2, 2, 2, 2), pk(2, 2, 2, 2, 2), 4, 1'b1, 1'b0);
        idle(5);
        expect_rec("after_clr", 24, 24, 6);

        // Asynchronous reset pulse mid-kernel.
        beat(pk(3, 3, 3, 3, 3), pk(3, 3, 3, 3, 3), 9, 1'b0, 1'b0);
        #2 global_rst_n = 1'b0;
        #1;
        chk("arst_o_valid", longint'(o_valid), 0);
        chk("arst_o_acc", longint'(o_acc), 0);
        chk("arst_o_data", longint'(o_data), 0);
        model_flush();
        @(negedge clk);
        global_rst_n = 1'b1;
        idle(4);
        beat(pk(1, 1, 1, 1, 1), pk(-1, -1, -1, -1, -1), -2, 1'b1, 1'b0);
        idle(5);
        expect_rec("after_arst", -7, -7, -2);

        chk("drain_exp_q", longint'(exp_q.size()), 0);
        chk("drain_rec_q", longint'(rec_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
